// File: rtl/hilo_ctrl.sv
// hilo_ctrl
//   Owns the architectural HI/LO registers in front of an iterative multiplier.
//   Issues a one-cycle start pulse, counts the multiply latency, commits the
//   multiplier's hi/lo result, services MTHI/MTLO writes and raises a
//   fetch/decode stall while a multiply is in flight.
//
// Optional feature (macro HILO_FWD_EN):
//   defined   - HiOut/LoOut bypass same-cycle MTHI/MTLO data (not in COMMIT)
//   undefined - HiOut/LoOut are pure register outputs (one-cycle write latency)
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   MultD, MultSgnD     decode-stage mult/multu request and its signedness
//   MfhiD, MfloD        decode-stage HI/LO reads (only used for stalling)
//   MthiW, MtloW        writeback HI/LO writes, data on WriteDataW
//   MultHi, MultLo      multiplier result, sampled in COMMIT
//   MultDone            multiplier completed flag, checked in COMMIT
//   MultE, MultSgnE     start pulse and sign select to the multiplier
//   HiOut, LoOut        architectural HI/LO
//   StallMD             stall fetch/decode
//   Busy                multiply in flight (START, RUN, COMMIT)
//   MdErr               sticky: MultDone was low at commit
//   StateDbg            current FSM state (IDLE=0, START=1, RUN=2, COMMIT=3)
//
// Handshake: a mult request is accepted in any IDLE cycle with MultD=1; while
// Busy, requests and HI/LO reads are held in decode by StallMD.
module hilo_ctrl #(
    parameter int LATENCY = 33,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MultD,
    input  logic        MultSgnD,
    input  logic        MfhiD,
    input  logic        MfloD,
    input  logic        MthiW,
    input  logic        MtloW,
    input  logic [31:0] WriteDataW,
    input  logic [31:0] MultHi,
    input  logic [31:0] MultLo,
    input  logic        MultDone,
    output logic        MultE,
    output logic        MultSgnE,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        StallMD,
    output logic        Busy,
    output logic        MdErr,
    output logic [1:0]  StateDbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        RUN    = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mult_e_q, mult_e_d;
    logic              sgn_q, sgn_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic              md_err_q, md_err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mult_e_q <= 1'b0;
            sgn_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            md_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mult_e_q <= mult_e_d;
            sgn_q    <= sgn_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            md_err_q <= md_err_d;
        end
    end

    // The start-pulse cycle is cycle 0. START loads 1 so that the counter
    // equals the cycle index; COMMIT is entered with counter==LATENCY, i.e.
    // exactly when the multiplier result becomes valid. Needs LATENCY >= 2.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mult_e_d = 1'b0;
        sgn_d    = sgn_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        md_err_d = md_err_q;

        // MTHI/MTLO write in every state; COMMIT below overrides them.
        if (MthiW) hi_d = WriteDataW;
        if (MtloW) lo_d = WriteDataW;

        unique case (state_q)
            IDLE: begin
                if (MultD) begin
                    mult_e_d = 1'b1;
                    sgn_d    = MultSgnD;
                    state_d  = START;
                end
            end
            START: begin
                cnt_d   = CNT_W'(1);
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == LAT_C) state_d = COMMIT;
            end
            COMMIT: begin
                // The mult was issued after any in-flight MTHI/MTLO, so it wins.
                hi_d = MultHi;
                lo_d = MultLo;
                if (!MultDone) md_err_d = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Busy     = (state_q != IDLE);
    assign StallMD  = Busy & (MfhiD | MfloD | MultD);
    assign MultE    = mult_e_q;
    assign MultSgnE = sgn_q;
    assign MdErr    = md_err_q;
    assign StateDbg = state_q;

`ifdef HILO_FWD_EN
    assign HiOut = (MthiW && state_q != COMMIT) ? WriteDataW : hi_q;
    assign LoOut = (MtloW && state_q != COMMIT) ? WriteDataW : lo_q;
`else
    assign HiOut = hi_q;
    assign LoOut = lo_q;
`endif

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
Downstream consumer of the iterative multiplier. It owns the architectural HI/LO registers and issues a one-cycle start pulse to the multiplier. It tracks the multiply latency, commits the multiplier's hi/lo result, and services MTHI/MTLO writes and MFHI/MFLO reads. It raises a pipeline stall when an instruction needs HI/LO, or needs the multiplier, while a multiply is in flight.

Parameters:
LATENCY, 33, cycles from start pulse to valid hi/lo at multiplier outputs (counted from the start-pulse cycle).
CNT_W, 6, width of internal latency counter; must satisfy 2^CNT_W > LATENCY.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
MultD  in  1  decode-stage mult/multu request
MultSgnD  in  1  1 = signed (mult), 0 = unsigned (multu)
MfhiD  in  1  decode-stage MFHI
MfloD  in  1  decode-stage MFLO
MthiW  in  1  writeback MTHI
MtloW  in  1  writeback MTLO
WriteDataW  in  32  data for MTHI/MTLO
MultHi  in  32  multiplier hi output
MultLo  in  32  multiplier lo output
MultDone  in  1  multiplier completed flag
MultE  out  1  start pulse to multiplier
MultSgnE  out  1  sign select to multiplier
HiOut  out  32  architectural HI
LoOut  out  32  architectural LO
StallMD  out  1  stall fetch/decode
Busy  out  1  multiply in flight
MdErr  out  1  sticky: MultDone low at commit

Behaviour:
- Reset (rst=0, async): HiOut=0, LoOut=0, MultE=0, MultSgnE=0, StallMD=0, Busy=0, MdErr=0, counter=0, state=IDLE.
- FSM states: IDLE, START, RUN, COMMIT.
- IDLE, MultD=1: registers MultE=1 and MultSgnE=MultSgnD, then goes to START.
- START: MultE is high for exactly this one cycle. Counter is set to 1. Next state is RUN.
- RUN: counter increments each cycle. When counter==LATENCY, go to COMMIT.
- COMMIT (one cycle):
  - HiOut<=MultHi and LoOut<=MultLo.
  - If MultDone=0, set MdErr=1 (sticky until reset). The result is committed anyway.
  - Next state is IDLE.
- Busy=1 in START, RUN and COMMIT.
- StallMD is combinational: StallMD = Busy & (MfhiD | MfloD | MultD).
  - A second mult is held in decode until IDLE. It cannot restart the multiplier mid-operation.
  - An MFHI/MFLO in the cycle after COMMIT reads the new value.
- MultD in IDLE with no stall: the start is accepted in that cycle. StallMD stays 0 in that cycle because Busy=0.
- MTHI/MTLO:
  - In IDLE, MthiW writes HiOut<=WriteDataW and MtloW writes LoOut<=WriteDataW on the next edge.
  - Both may be set in the same cycle; both registers update.
  - While Busy, MTHI/MTLO still write immediately.
  - In COMMIT, the multiplier result overrides any same-cycle MTHI/MTLO (the later-issued mult wins).
- Reset mid-operation: returns to IDLE and clears everything. The multiplier is not re-started.
- HiOut and LoOut are registered outputs; no combinational path from MultHi/MultLo.

Optional Feature:
Macro HILO_FWD_EN.
- Defined: HiOut/LoOut bypass the same-cycle MTHI/MTLO data. HiOut = MthiW ? WriteDataW : hi_q, and likewise for LoOut. The bypass is suppressed in COMMIT.
- Undefined: HiOut/LoOut are pure register outputs with one-cycle write latency.

Test Plan:
- Reset low mid-RUN (counter=10) → all outputs 0 and state IDLE immediately. A new MultD then starts cleanly with MultE pulsing once.
- multu 3×5 (MultSgnD=0), multiplier model returns hi=0, lo=15 with MultDone=1 at LATENCY → MultE high exactly one cycle. HiOut=0x00000000 and LoOut=0x0000000F one cycle after COMMIT. Busy high for LATENCY+1 cycles.
- mult −2×3 (MultSgnD=1), model hi=0xFFFFFFFF, lo=0xFFFFFFFA → MultSgnE=1 during START. HiOut=0xFFFFFFFF and LoOut=0xFFFFFFFA after commit.
- MfhiD and a second MultD held high throughout RUN → StallMD=1 every Busy cycle and 0 in the first IDLE cycle. Second MultE pulse occurs only after IDLE.
- MthiW=1, WriteDataW=0xDEADBEEF in IDLE → HiOut=0xDEADBEEF next cycle (same cycle with HILO_FWD_EN). LoOut unchanged. In COMMIT with MtloW=1, LoOut takes MultLo instead.
- Model holds MultDone=0 at counter==LATENCY → MdErr=1 and stays set across subsequent multiplies until rst=0.
